// File: rtl/icache_rd_responder.sv
// Instruction-memory model for the i-cache refill channel: accepts one line
// address, waits RD_LAT cycles, then streams a BURST_LEN-word burst.
module icache_rd_responder #(
  parameter int MEM_WORDS = 4096,
  parameter int BURST_LEN = 4,
  parameter int RD_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_arvalid,
  input  logic [31:0] i_araddr,
  output logic        i_arready,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  input  logic        i_rready,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int LB = $clog2(BURST_LEN);
  localparam int LW = AW - LB;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

  state_t          state_q;
  logic            arready_q;
  logic            rvalid_q;
  logic            rlast_q;
  logic [31:0]     rdata_q;
  logic [LB-1:0]   beat_q;
  logic [LB-1:0]   beat_d;
  logic [CW-1:0]   lat_q;
  logic [LW-1:0]   base_q;
  logic [31:0]     mem_q [MEM_WORDS];
  logic            ar_hs;
  logic            unused_addr_bits;

  assign ar_hs  = (state_q == S_IDLE) && i_arvalid && arready_q;
  assign beat_d = beat_q + 1'b1;

  // Byte-offset bits within a line and bits above the array are don't-care.
  assign unused_addr_bits = ^{i_araddr[31:AW+2], i_araddr[LB+1:0],
                              ld_addr[31:AW+2], ld_addr[1:0]};

  always_ff @(posedge clk) begin
    if (ld_we) mem_q[ld_addr[AW+1:2]] <= ld_wdata;
  end

  always_ff @(posedge clk) begin
    if (ar_hs) base_q <= i_araddr[AW+1:LB+2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ar_hs) begin
            arready_q <= 1'b0;
            lat_q     <= CW'(RD_LAT - 1);
            state_q   <= S_WAIT;
          end else begin
            arready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (lat_q == '0) begin
            rdata_q  <= mem_q[{base_q, LB'(0)}];
            rvalid_q <= 1'b1;
            rlast_q  <= (BURST_LEN == 1);
            beat_q   <= '0;
            state_q  <= S_DATA;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        S_DATA: begin
          // Each beat is fetched on the edge that retires the previous one,
          // so loader writes landing before that edge are visible.
          if (i_rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              state_q   <= S_IDLE;
            end else begin
              beat_q  <= beat_d;
              rdata_q <= mem_q[{base_q, beat_d}];
              rlast_q <= (beat_d == LB'(BURST_LEN - 1));
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign i_arready = arready_q;
  assign i_rvalid  = rvalid_q;
  assign i_rdata   = rdata_q;
  assign i_rlast   = rlast_q;

endmodule

// File: tb/tb_icache_rd_responder.sv
// Randomised scoreboard bench for icache_rd_responder: expected bursts come
// from a word-array model of the backing store and are checked by a monitor.
module tb_icache_rd_responder;

  localparam int MEM_WORDS = 4096;
  localparam int BURST_LEN = 4;
  localparam int RD_LAT    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_arvalid;
  logic [31:0] i_araddr;
  logic        i_arready;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_rlast;
  logic        i_rready;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;

  icache_rd_responder #(
    .MEM_WORDS(MEM_WORDS), .BURST_LEN(BURST_LEN), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arready(i_arready),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rready(i_rready),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata)
  );

  always #5 clk = ~clk;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  logic [32:0] exp_q[$];
  logic [31:0] mem_m [MEM_WORDS];

  function automatic void check(input string name, input logic [32:0] act, input logic [32:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % MEM_WORDS);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: beat scoreboard, stall stability, first-beat latency, arready.
  logic        prev_stall, prev_rv, prev_last_hs, hs_pending;
  logic [32:0] prev_beat;
  int          hs_cyc;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0; prev_rv = 0; prev_last_hs = 0; hs_pending = 0;
    end else begin
      if (prev_last_hs) check("arready_after_last", 33'(i_arready), 33'(1));
      if (prev_stall) begin
        check("stall_valid", 33'(i_rvalid), 33'(1));
        check("stall_beat", {i_rlast, i_rdata}, prev_beat);
      end
      if (i_rvalid) check("arready_low_in_burst", 33'(i_arready), 33'(0));
      if (i_rvalid && !prev_rv && hs_pending) begin
        check("first_beat_latency", 33'(cyc - hs_cyc), 33'(RD_LAT + 1));
        hs_pending = 0;
      end
      if (i_arvalid && i_arready) begin
        hs_cyc = cyc; hs_pending = 1;
      end
      if (i_rvalid && i_rready) begin
        if (exp_q.size() == 0) check("unexpected_beat", {i_rlast, i_rdata}, 33'h0_dead_beef);
        else check("beat", {i_rlast, i_rdata}, exp_q.pop_front());
      end
      prev_stall   = i_rvalid && !i_rready;
      prev_beat    = {i_rlast, i_rdata};
      prev_rv      = i_rvalid;
      prev_last_hs = i_rvalid && i_rready && i_rlast;
    end
  end

  task automatic ld_write(input int widx, input logic [31:0] d);
    ld_we    = 1'b1;
    ld_addr  = (32'(widx) << 2) | 32'($urandom_range(0, 3));
    ld_wdata = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
    mem_m[widx] = d;
  endtask

  task automatic issue_ar(input logic [31:0] addr, input bit expect_now);
    bit ok = 0;
    int waited = 0;
    i_arvalid = 1'b1;
    i_araddr  = addr;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i_arready) begin ok = 1; break; end
      @(posedge clk); #1;
      waited++;
    end
    check("ar_accept", 33'(ok), 33'(1));
    if (expect_now) check("ar_back_to_back", 33'(waited), 33'(0));
    @(posedge clk); #1;
  endtask

  task automatic push_burst(input logic [31:0] addr);
    int base;
    base = word_of(addr) & ~(BURST_LEN - 1);
    for (int b = 0; b < BURST_LEN; b++)
      exp_q.push_back({(b == BURST_LEN - 1), mem_m[base + b]});
  endtask

  // mode 0: always ready, 1: random, 2: scripted 1,0,0,1,0,1,1 per valid cycle
  task automatic drain(input int mode);
    logic [6:0] pat = 7'b1101001;
    int pidx = 0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      case (mode)
        0: i_rready = 1'b1;
        1: i_rready = 1'($urandom_range(0, 1));
        default: begin
          i_rready = i_rvalid ? pat[pidx % 7] : 1'b0;
          if (i_rvalid) pidx++;
        end
      endcase
      @(posedge clk); #1;
    end
    check("burst_complete", 33'(exp_q.size()), 33'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int w;
    rst = 1'b1; i_arvalid = 0; i_araddr = 0; i_rready = 0;
    ld_we = 0; ld_addr = 0; ld_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 33'(i_arready), 33'(0));
    check("rst_rvalid", 33'(i_rvalid), 33'(0));
    check("rst_rlast", 33'(i_rlast), 33'(0));
    check("rst_rdata", 33'(i_rdata), 33'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("arready_after_rst", 33'(i_arready), 33'(1));

    for (int i = 0; i < 512; i++)
      ld_write(i, (i >= 256 && i < 260) ? 32'(32'hA0 + i - 256) : $urandom);

    // Basic aligned burst
    issue_ar(32'h0000_0400, 0);
    i_arvalid = 0;
    check("arready_drop", 33'(i_arready), 33'(0));
    push_burst(32'h0000_0400);
    drain(0);

    // Scripted backpressure
    i_rready = 0;
    issue_ar(32'h0000_0400, 0);
    i_arvalid = 0;
    push_burst(32'h0000_0400);
    drain(2);

    // Unaligned address aligns down to the line
    issue_ar(32'h0000_040C, 0);
    i_arvalid = 0;
    exp_q.push_back({1'b0, 32'hA0}); exp_q.push_back({1'b0, 32'hA1});
    exp_q.push_back({1'b0, 32'hA2}); exp_q.push_back({1'b1, 32'hA3});
    drain(0);

    // Back-to-back with arvalid held high
    issue_ar(32'h0000_0400, 0);
    push_burst(32'h0000_0400);
    drain(0);
    issue_ar(32'h0000_0810, 1);
    i_arvalid = 0;
    push_burst(32'h0000_0810);
    drain(0);

    // Loader write during WAIT reaches a later beat
    issue_ar(32'h0000_0400, 0);
    i_arvalid = 0;
    ld_write(32'h102, 32'h55);
    push_burst(32'h0000_0400);
    drain(0);

    // Loader write to a beat already on the bus does not disturb it
    i_rready = 0;
    issue_ar(32'h0000_0400, 0);
    i_arvalid = 0;
    push_burst(32'h0000_0400);
    for (int i = 0; i < 20 && !i_rvalid; i++) begin @(posedge clk); #1; end
    ld_write(32'h100, 32'h77);
    @(posedge clk); #1;
    drain(0);
    ld_write(32'h100, 32'hA0);

    // Reset during beat 2
    i_rready = 1;
    issue_ar(32'h0000_0400, 0);
    i_arvalid = 0;
    push_burst(32'h0000_0400);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i_rvalid && i_rdata == mem_m[32'h102]) break;
    end
    #1 rst = 1'b1;
    #1;
    check("midrst_arready", 33'(i_arready), 33'(0));
    check("midrst_rvalid", 33'(i_rvalid), 33'(0));
    check("midrst_rlast", 33'(i_rlast), 33'(0));
    check("midrst_rdata", 33'(i_rdata), 33'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("arready_after_midrst", 33'(i_arready), 33'(1));
    check("rvalid_after_midrst", 33'(i_rvalid), 33'(0));
    issue_ar(32'h0000_0810, 0);
    i_arvalid = 0;
    push_burst(32'h0000_0810);
    drain(1);

    // Randomised bursts, aliased addresses, loader traffic
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) ld_write($urandom_range(0, 511), $urandom);
      w = $urandom_range(0, 511);
      a = (32'($urandom_range(0, 3)) << 14) | (32'(w) << 2) | 32'($urandom_range(0, 3));
      issue_ar(a, 0);
      i_arvalid = 0;
      if ($urandom_range(0, 1) == 1)
        ld_write((w & ~(BURST_LEN - 1)) + $urandom_range(0, BURST_LEN - 1), $urandom);
      push_burst(a);
      drain($urandom_range(0, 1));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
